bcd_counter_ctrl: RTL and testbench

BCD_COUNTER_CTRL -- requirements
Module: bcd_counter_ctrl

---
 rtl/bcd_counter_ctrl_pkg.sv | 79 +++++++
 rtl/bcd_counter_ctrl_debounce.sv | 89 ++++++++
 rtl/bcd_counter_ctrl.sv | 95 +++++++++
 tb/tb_bcd_counter_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_ctrl_pkg.sv
// Shared types, constants and BCD step helpers for bcd_counter_ctrl.
// Debouncer state encoding, digit geometry and default parameter values.
package bcd_counter_ctrl_pkg;

  localparam int BCD_W = 4;
  localparam int NUM_DIGITS = 4;
  localparam int CNT_W = BCD_W * NUM_DIGITS;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REFRESH_DIV = 100000;

  typedef enum logic [1:0] {
    DB_IDLE        = 2'd0,
    DB_ARM_PRESS   = 2'd1,
    DB_PRESSED     = 2'd2,
    DB_ARM_RELEASE = 2'd3
  } db_state_t;

  typedef struct packed {
    logic             wrap;
    logic [CNT_W-1:0] value;
  } bcd_step_t;

  // Ripple +1 through the digits; a carry out of
  // the top digit means the counter wrapped.
  function automatic bcd_step_t bcd_inc(
    input logic [CNT_W-1:0] v
  );
    bcd_step_t        r;
    logic             c;
    logic [BCD_W-1:0] d;
    c = 1'b1;
    r.value = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*BCD_W +: BCD_W];
      if (c) begin
        if (d >= BCD_MAX) begin
          r.value[i*BCD_W +: BCD_W] = '0;
        end else begin
          r.value[i*BCD_W +: BCD_W] = d + 1'b1;
          c = 1'b0;
        end
      end
    end
    r.wrap = c;
    return r;
  endfunction

  // Ripple -1 through the digits; a borrow out of
  // the top digit means the counter wrapped.
  function automatic bcd_step_t bcd_dec(
    input logic [CNT_W-1:0] v
  );
    bcd_step_t        r;
    logic             b;
    logic [BCD_W-1:0] d;
    b = 1'b1;
    r.value = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[i*BCD_W +: BCD_W];
      if (b) begin
        if (d == '0) begin
          r.value[i*BCD_W +: BCD_W] = BCD_MAX;
        end else if (d > BCD_MAX) begin
          r.value[i*BCD_W +: BCD_W] = BCD_MAX;
          b = 1'b0;
        end else begin
          r.value[i*BCD_W +: BCD_W] = d - 1'b1;
          b = 1'b0;
        end
      end
    end
    r.wrap = b;
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_debounce.sv
// button_debounce: 2-flop synchronizer plus press/release qualifier FSM.
// Ports: clk, reset (sync, high), btn (raw), press (one-cycle pulse).
module button_debounce
  import bcd_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1;
  logic            sync_q2;
  db_state_t       state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // The sample that leaves IDLE (or PRESSED) is the
  // first of the DEBOUNCE_CYCLES qualifying samples,
  // hence cnt starts at 1 on entry to an ARM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state)
        DB_IDLE: begin
          cnt <= '0;
          if (sync_q2) begin
            state <= DB_ARM_PRESS;
            cnt   <= CW'(1);
          end
        end
        DB_ARM_PRESS: begin
          if (!sync_q2) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= DB_PRESSED;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          cnt <= '0;
          if (!sync_q2) begin
            state <= DB_ARM_RELEASE;
            cnt   <= CW'(1);
          end
        end
        DB_ARM_RELEASE: begin
          if (sync_q2) begin
            state <= DB_PRESSED;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Four-digit BCD up/down counter driven by two debounced buttons,
// plus a free-running display refresh divider.
// Ports: clk, reset, btn_inc, btn_dec, clear, hold -> count[15:0],
//        refresh_tick, wrap.
module bcd_counter_ctrl
  import bcd_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REFRESH_DIV     = DEF_REFRESH_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             clear,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             refresh_tick,
  output logic             wrap
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE =
    DW'(REFRESH_DIV - 2);

  logic      inc_p;
  logic      dec_p;
  bcd_step_t inc_res;
  bcd_step_t dec_res;
  logic [DW-1:0] div;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_inc),
    .press(inc_p)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_dec),
    .press(dec_p)
  );

  always_comb begin
    inc_res = bcd_inc(count);
    dec_res = bcd_dec(count);
  end

  // Simultaneous inc and dec cancel; pulses seen
  // under hold are simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (hold) begin
        count <= count;
      end else if (inc_p && !dec_p) begin
        count <= inc_res.value;
        wrap  <= inc_res.wrap;
      end else if (dec_p && !inc_p) begin
        count <= dec_res.value;
        wrap  <= dec_res.wrap;
      end
    end
  end

  // Tick is registered from the pre-terminal value so
  // it is high exactly while div sits at its last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      refresh_tick <= 1'b0;
    end else begin
      refresh_tick <= (div == DIV_PRE);
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Self-checking bench for bcd_counter_ctrl (DEBOUNCE_CYCLES=4,
// REFRESH_DIV=8) against a decimal/run-length reference model.
module tb_bcd_counter_ctrl;

  localparam int D = 4;
  localparam int R = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_inc;
  logic        btn_dec;
  logic        clear;
  logic        hold;
  logic [15:0] count;
  logic        refresh_tick;
  logic        wrap;

  int total = 0;
  int bad = 0;

  bit clr_v;
  bit hld_v;
  bit rst_v;

  int m_cnt;
  int m_cyc;
  bit m_wrap;
  bit m_tick;
  bit m_q1[2];
  bit m_q2[2];
  bit m_lvl[2];
  bit m_pend[2];
  int m_run[2];

  bcd_counter_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REFRESH_DIV(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .clear(clear),
    .hold(hold),
    .count(count),
    .refresh_tick(refresh_tick),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model: synced sample lags raw by two edges; the
  // accepted level flips after D consecutive samples
  // that differ from it; a 0->1 flip is a press that
  // moves a plain decimal count on the next edge.
  task automatic model_edge(input bit ri, input bit rd);
    bit raw[2];
    bit s;
    raw[0] = ri;
    raw[1] = rd;
    if (rst_v) begin
      m_cnt = 0;
      m_wrap = 0;
      m_tick = 0;
      m_cyc = 0;
      for (int b = 0; b < 2; b++) begin
        m_q1[b] = 0;
        m_q2[b] = 0;
        m_lvl[b] = 0;
        m_pend[b] = 0;
        m_run[b] = 0;
      end
    end else begin
      m_wrap = 0;
      if (clr_v) begin
        m_cnt = 0;
      end else if (!hld_v && m_pend[0] != m_pend[1]) begin
        if (m_pend[0]) begin
          if (m_cnt == 9999) begin
            m_cnt = 0;
            m_wrap = 1;
          end else m_cnt++;
        end else begin
          if (m_cnt == 0) begin
            m_cnt = 9999;
            m_wrap = 1;
          end else m_cnt--;
        end
      end
      for (int b = 0; b < 2; b++) begin
        s = m_q2[b];
        m_pend[b] = 0;
        if (s != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_lvl[b] = s;
            m_run[b] = 0;
            m_pend[b] = s;
          end
        end else m_run[b] = 0;
        m_q2[b] = m_q1[b];
        m_q1[b] = raw[b];
      end
      m_cyc++;
      m_tick = ((m_cyc % R) == R - 1);
    end
  endtask

  task automatic cyc_step(input bit ri, input bit rd);
    @(negedge clk);
    btn_inc = ri;
    btn_dec = rd;
    clear = clr_v;
    hold = hld_v;
    reset = rst_v;
    @(posedge clk);
    model_edge(ri, rd);
    #1;
  endtask

  task automatic press_n(input bit up, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (8) cyc_step(up, !up);
      repeat (8) cyc_step(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_v = 1;
    clr_v = 1;
    hld_v = 1;
    for (int n = 0; n < 4; n++) begin
      cyc_step(1'b1, 1'b1);
      total++;
      if ({count, wrap, refresh_tick} !== 18'h0) begin
        bad++;
        $display("FAIL reset[%0d]: got count=%h wrap=%b tick=%b want 0000/0/0",
                 n, count, wrap, refresh_tick);
      end
    end
    rst_v = 0;
    clr_v = 0;
    hld_v = 0;
    repeat (12) cyc_step(1'b0, 1'b0);
    total++;
    if (count !== 16'h0000) begin
      bad++;
      $display("FAIL reset_after: got count=%h want 0000", count);
    end
  endtask

  task automatic test_single_press;
    logic [15:0] exp;
    rst_v = 1;
    cyc_step(1'b0, 1'b0);
    rst_v = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc_step(1'b1, 1'b0);
      exp = (n >= 7) ? 16'h0001 : 16'h0000;
      total++;
      if (count !== exp ||
          {wrap, refresh_tick} !== {m_wrap, m_tick}) begin
        bad++;
        $display("FAIL single_press[%0d]: got %h/%b/%b want %h/%b/%b",
                 n, count, wrap, refresh_tick, exp, m_wrap, m_tick);
      end
    end
    repeat (12) cyc_step(1'b0, 1'b0);
    total++;
    if (count !== 16'h0001) begin
      bad++;
      $display("FAIL single_release: got %h want 0001", count);
    end
  endtask

  task automatic test_bounce;
    bit pat[5];
    logic [15:0] base;
    logic [15:0] exp;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    base = count;
    for (int n = 1; n <= 16; n++) begin
      cyc_step((n <= 5) ? pat[n-1] : 1'b1, 1'b0);
      exp = (n >= 11) ? base + 16'h1 : base;
      total++;
      if (count !== exp || count !== to_bcd(m_cnt)) begin
        bad++;
        $display("FAIL bounce[%0d]: got %h want %h (model %h)",
                 n, count, exp, to_bcd(m_cnt));
      end
    end
    repeat (12) cyc_step(1'b0, 1'b0);
  endtask

  task automatic test_carry;
    int wraps;
    clr_v = 1;
    cyc_step(1'b0, 1'b0);
    clr_v = 0;
    press_n(1'b1, 99);
    total++;
    if (count !== 16'h0099) begin
      bad++;
      $display("FAIL preload_99: got %h want 0099", count);
    end
    press_n(1'b1, 1);
    total++;
    if (count !== 16'h0100) begin
      bad++;
      $display("FAIL carry_100: got %h want 0100", count);
    end
    clr_v = 1;
    cyc_step(1'b0, 1'b0);
    clr_v = 0;
    for (int dir = 0; dir < 2; dir++) begin
      wraps = 0;
      for (int n = 0; n < 16; n++) begin
        cyc_step(n < 8 && dir == 0 ? 1'b0 : (n < 8),
                 n < 8 && dir == 0);
        if (wrap === 1'b1) wraps++;
        total++;
        if ({count, wrap, refresh_tick} !==
            {to_bcd(m_cnt), m_wrap, m_tick}) begin
          bad++;
          $display("FAIL wrap_dir%0d[%0d]: got %h/%b/%b want %h/%b/%b",
                   dir, n, count, wrap, refresh_tick,
                   to_bcd(m_cnt), m_wrap, m_tick);
        end
      end
      total++;
      if (wraps != 1 ||
          count !== (dir == 0 ? 16'h9999 : 16'h0000)) begin
        bad++;
        $display("FAIL wrap_end_dir%0d: got count=%h wraps=%0d want %h/1",
                 dir, count, wraps, dir == 0 ? 16'h9999 : 16'h0000);
      end
    end
  endtask

  task automatic test_hold_clear;
    clr_v = 1;
    cyc_step(1'b0, 1'b0);
    clr_v = 0;
    press_n(1'b1, 3);
    hld_v = 1;
    press_n(1'b1, 2);
    press_n(1'b0, 1);
    total++;
    if (count !== 16'h0003) begin
      bad++;
      $display("FAIL hold_press: got %h want 0003", count);
    end
    hld_v = 0;
    repeat (12) cyc_step(1'b0, 1'b0);
    total++;
    if (count !== 16'h0003 || count !== to_bcd(m_cnt)) begin
      bad++;
      $display("FAIL hold_replay: got %h want 0003", count);
    end
    clr_v = 1;
    for (int n = 0; n < 10; n++) begin
      cyc_step(1'b1, 1'b0);
      total++;
      if (count !== 16'h0000 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL clear_inc[%0d]: got %h/%b want 0000/0",
                 n, count, wrap);
      end
    end
    clr_v = 0;
    repeat (10) cyc_step(1'b0, 1'b0);
  endtask

  task automatic test_cancel;
    clr_v = 1;
    cyc_step(1'b0, 1'b0);
    clr_v = 0;
    press_n(1'b1, 42);
    for (int n = 0; n < 16; n++) begin
      cyc_step(n < 8, n < 8);
      total++;
      if (count !== 16'h0042 || wrap !== 1'b0 ||
          count !== to_bcd(m_cnt)) begin
        bad++;
        $display("FAIL cancel[%0d]: got %h/%b want 0042/0",
                 n, count, wrap);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] exp;
    rst_v = 1;
    cyc_step(1'b0, 1'b0);
    rst_v = 0;
    repeat (4) cyc_step(1'b1, 1'b0);
    rst_v = 1;
    cyc_step(1'b1, 1'b0);
    rst_v = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc_step(1'b1, 1'b0);
      exp = (n >= 7) ? 16'h0001 : 16'h0000;
      total++;
      if (count !== exp || count !== to_bcd(m_cnt)) begin
        bad++;
        $display("FAIL reset_mid[%0d]: got %h want %h", n, count, exp);
      end
    end
    repeat (12) cyc_step(1'b0, 1'b0);
  endtask

  task automatic test_refresh;
    bit exp;
    rst_v = 1;
    cyc_step(1'b0, 1'b0);
    rst_v = 0;
    for (int k = 1; k <= 40; k++) begin
      hld_v = $urandom_range(1);
      clr_v = $urandom_range(1);
      cyc_step(1'b0, 1'b0);
      exp = ((k % R) == R - 1);
      total++;
      if (refresh_tick !== exp || refresh_tick !== m_tick) begin
        bad++;
        $display("FAIL refresh[%0d]: got %b want %b", k, refresh_tick, exp);
      end
    end
    hld_v = 0;
    clr_v = 0;
  endtask

  task automatic test_random;
    bit ri;
    bit rd;
    ri = 0;
    rd = 0;
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(7) == 0) ri = !ri;
      if ($urandom_range(7) == 0) rd = !rd;
      if ($urandom_range(15) == 0) hld_v = !hld_v;
      clr_v = ($urandom_range(59) == 0);
      rst_v = ($urandom_range(299) == 0);
      cyc_step(ri, rd);
      total++;
      if ({count, wrap, refresh_tick} !==
          {to_bcd(m_cnt), m_wrap, m_tick}) begin
        bad++;
        $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b",
                 n, count, wrap, refresh_tick,
                 to_bcd(m_cnt), m_wrap, m_tick);
      end
    end
    hld_v = 0;
    clr_v = 0;
    rst_v = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    clear = 1'b0;
    hold = 1'b0;
    clr_v = 0;
    hld_v = 0;
    rst_v = 1;
    test_reset();
    test_single_press();
    test_bounce();
    test_carry();
    test_hold_clear();
    test_cancel();
    test_reset_mid();
    test_refresh();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
